y86_seq_backend: RTL and testbench

- Decode/execute/memory/write-back datapath of the Y86-64 sequential (SEQ) processor.
- Takes fetched instruction fields and produces valA, valB, valE, valM, Cnd and stat.
- Register file, condition codes and data memory update on the rising clock edge.
- The external fetch and pc_update blocks consume valE, valM and Cnd combinationally within the same cycle.

---
 rtl/y86_seq_backend_if.sv | 28 ++
 rtl/y86_seq_backend.sv | 155 +++++++++++++++
 tb/tb_y86_seq_backend.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_seq_backend_if.sv
// Instruction-field / result bundle between the SEQ fetch stage and the backend datapath.
// The master (fetch side) drives the decoded fields; the slave (backend) returns the results.
interface y86_seq_backend_if;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        Cnd;
    logic [1:0]  stat;

    modport master (
        output icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
        input  valA, valB, valE, valM, Cnd, stat
    );

    modport slave (
        input  icode, ifun, rA, rB, valC, valP, instr_valid, imem_error,
        output valA, valB, valE, valM, Cnd, stat
    );
endinterface

// File: rtl/y86_seq_backend.sv
// Y86-64 SEQ decode/execute/memory/write-back: register file, ALU, condition codes, data memory.
// Everything is combinational except the register file, CC and memory, which update on posedge.
module y86_seq_backend #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    y86_seq_backend_if.slave   bus
);
    localparam int AW = $clog2(DMEM_BYTES);
    localparam logic [3:0] I_HALT = 4'h0, I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4,
                           I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8,
                           I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    localparam logic [3:0] RNONE = 4'hF, RRSP = 4'h4;
    localparam logic [1:0] S_AOK = 2'd0, S_HLT = 2'd1, S_ADR = 2'd2, S_INS = 2'd3;

    logic [63:0] rf_q [15];
    logic [7:0]  mem_q [DMEM_BYTES];
    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic signed [63:0] alu_a, alu_b, alu_res;
    logic [63:0] mem_addr, mem_wdata, rd_word;
    logic [AW-1:0] mem_base;
    logic        mem_rd, mem_wr, dmem_err, cond, wr_en;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = bus.rA;
            I_RET, I_POP:                    src_a = RRSP;
            default: ;
        endcase
        case (bus.icode)
            I_RRMOV, I_RMMOV, I_MRMOV, I_OPQ:  src_b = bus.rB;
            I_CALL, I_RET, I_PUSH, I_POP:      src_b = RRSP;
            default: ;
        endcase
        if (bus.icode == I_MRMOV || bus.icode == I_POP) dst_m = bus.rA;
    end

    assign bus.valA = (src_a == RNONE) ? 64'd0 : rf_q[src_a];
    assign bus.valB = (src_b == RNONE) ? 64'd0 : rf_q[src_b];

    // Execute: operands treated as signed so the overflow rules read naturally.
    always_comb begin
        alu_a   = signed'(bus.valA);
        alu_b   = signed'(bus.valB);
        alu_res = '0;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        case (bus.icode)
            I_RRMOV:          alu_res = alu_a;
            I_IRMOV:          alu_res = signed'(bus.valC);
            I_RMMOV, I_MRMOV: alu_res = alu_b + signed'(bus.valC);
            I_CALL, I_PUSH:   alu_res = alu_b - 64'sd8;
            I_RET, I_POP:     alu_res = alu_b + 64'sd8;
            I_OPQ: begin
                case (bus.ifun)
                    4'h0:    alu_res = alu_b + alu_a;
                    4'h1:    alu_res = alu_b - alu_a;
                    4'h2:    alu_res = alu_b & alu_a;
                    4'h3:    alu_res = alu_b ^ alu_a;
                    default: alu_res = '0;
                endcase
                zf_d = (alu_res == 64'sd0);
                sf_d = alu_res[63];
                case (bus.ifun)
                    4'h0:    of_d = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_b[63]);
                    4'h1:    of_d = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
                    default: of_d = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.valE = unsigned'(alu_res);

    always_comb begin
        cond = 1'b0;
        if (bus.icode == I_RRMOV || bus.icode == I_JXX) begin
            case (bus.ifun)
                4'h0:    cond = 1'b1;
                4'h1:    cond = (sf_q ^ of_q) | zf_q;
                4'h2:    cond = sf_q ^ of_q;
                4'h3:    cond = zf_q;
                4'h4:    cond = ~zf_q;
                4'h5:    cond = ~(sf_q ^ of_q);
                4'h6:    cond = ~(sf_q ^ of_q) & ~zf_q;
                default: cond = 1'b0;
            endcase
        end
    end

    assign bus.Cnd = cond;

    always_comb begin
        dst_e = RNONE;
        case (bus.icode)
            I_IRMOV, I_OPQ:               dst_e = bus.rB;
            I_RRMOV:                      dst_e = cond ? bus.rB : RNONE;
            I_CALL, I_RET, I_PUSH, I_POP: dst_e = RRSP;
            default: ;
        endcase
    end

    // Memory stage: the range check is done one bit wider so addresses near 2^64 cannot wrap.
    always_comb begin
        mem_rd    = (bus.icode == I_MRMOV) || (bus.icode == I_RET) || (bus.icode == I_POP);
        mem_wr    = (bus.icode == I_RMMOV) || (bus.icode == I_CALL) || (bus.icode == I_PUSH);
        mem_addr  = (bus.icode == I_RET || bus.icode == I_POP) ? bus.valA : bus.valE;
        mem_wdata = (bus.icode == I_CALL) ? bus.valP : bus.valA;
        dmem_err  = (mem_rd || mem_wr) && (({1'b0, mem_addr} + 65'd8) > 65'(DMEM_BYTES));
        mem_base  = mem_addr[AW-1:0];
        rd_word   = '0;
        for (int k = 0; k < 8; k++) rd_word[8*k +: 8] = mem_q[mem_base + AW'(k)];
    end

    assign bus.valM = (mem_rd && !dmem_err) ? rd_word : 64'd0;

    always_comb begin
        if (bus.imem_error || dmem_err) bus.stat = S_ADR;
        else if (!bus.instr_valid)      bus.stat = S_INS;
        else if (bus.icode == I_HALT)   bus.stat = S_HLT;
        else                            bus.stat = S_AOK;
    end

    assign wr_en = (bus.stat == S_AOK);

    // State update: dstM is written after dstE so it wins on a collision (popq %rsp).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= '0;
            for (int j = 0; j < DMEM_BYTES; j++) mem_q[j] <= '0;
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (wr_en) begin
            if (bus.icode == I_OPQ) begin
                zf_q <= zf_d;
                sf_q <= sf_d;
                of_q <= of_d;
            end
            if (dst_e != RNONE) rf_q[dst_e] <= bus.valE;
            if (dst_m != RNONE) rf_q[dst_m] <= bus.valM;
            if (mem_wr)
                for (int k = 0; k < 8; k++) mem_q[mem_base + AW'(k)] <= mem_wdata[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_y86_seq_backend.sv
// Scoreboard bench for y86_seq_backend: each instruction queues its expected outputs,
// which are popped and compared on the falling edge before the state-updating edge.
module tb_y86_seq_backend;
    localparam int DMEM_BYTES = 1024;
    localparam int O_VALA = 0, O_VALB = 1, O_VALE = 2, O_VALM = 3, O_CND = 4, O_STAT = 5;

    logic clk;
    logic reset;
    y86_seq_backend_if bus();

    y86_seq_backend #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            O_VALA:  return bus.valA;
            O_VALB:  return bus.valB;
            O_VALE:  return bus.valE;
            O_VALM:  return bus.valM;
            O_CND:   return {63'd0, bus.Cnd};
            default: return {62'd0, bus.stat};
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic [63:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                         input logic iv = 1'b1, input logic ime = 1'b0);
        bus.icode       = ic;
        bus.ifun        = fn;
        bus.rA          = ra;
        bus.rB          = rb;
        bus.valC        = c;
        bus.valP        = p;
        bus.instr_valid = iv;
        bus.imem_error  = ime;
    endtask

    // Pop every queued expectation before the edge, then let the edge commit state.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic irmov(input logic [3:0] rb, input logic [63:0] c);
        drive(4'h3, 4'h0, 4'hF, rb, c, 64'd0);
        step();
    endtask

    task automatic read_reg(input logic [3:0] r, input string tag, input logic [63:0] v);
        drive(4'h2, 4'h0, r, 4'hF, 64'd0, 64'd0);
        expect_out(O_VALA, tag, v);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        drive(4'h2, 4'h0, 4'h2, 4'h3, 64'd0, 64'd0);
        expect_out(O_VALA, "rst_valA", 64'd0);
        expect_out(O_VALB, "rst_valB", 64'd0);
        expect_out(O_STAT, "rst_stat", 64'd0);
        step();
        drive(4'h7, 4'h3, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "rst_zf_je", 64'd1);
        step();

        // irmovq then read back
        drive(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'd0);
        expect_out(O_VALE, "irmov_valE", 64'h10);
        step();
        read_reg(4'h2, "irmov_rd", 64'h10);

        // rrmovq r2->r6, then OPq add to clear ZF, then sub to set it
        drive(4'h2, 4'h0, 4'h2, 4'h6, 64'd0, 64'd0);
        expect_out(O_VALE, "rrmov_valE", 64'h10);
        expect_out(O_CND, "rrmov_cnd", 64'd1);
        step();
        irmov(4'h2, 64'd5);
        irmov(4'h3, 64'd5);
        drive(4'h6, 4'h0, 4'h2, 4'h6, 64'd0, 64'd0);
        expect_out(O_VALE, "add_valE", 64'h15);
        step();
        drive(4'h7, 4'h3, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "je_nz", 64'd0);
        step();
        drive(4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'd0);
        expect_out(O_VALA, "sub_valA", 64'd5);
        expect_out(O_VALB, "sub_valB", 64'd5);
        expect_out(O_VALE, "sub_valE", 64'd0);
        step();
        drive(4'h2, 4'h4, 4'h2, 4'h7, 64'd0, 64'd0);
        expect_out(O_CND, "cmovne_cnd", 64'd0);
        step();
        read_reg(4'h7, "cmovne_nowr", 64'd0);
        read_reg(4'h3, "sub_wb", 64'd0);

        // Stack round trip
        irmov(4'h4, 64'h100);
        irmov(4'h2, 64'hDEAD);
        drive(4'hA, 4'h0, 4'h2, 4'hF, 64'd0, 64'd0);
        expect_out(O_VALA, "push_valA", 64'hDEAD);
        expect_out(O_VALE, "push_valE", 64'hF8);
        step();
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'hF8, 64'd0);
        expect_out(O_VALM, "push_mem", 64'hDEAD);
        step();
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'hF9, 64'd0);
        expect_out(O_VALM, "mem_le", 64'hDE);
        step();
        drive(4'hB, 4'h0, 4'h5, 4'hF, 64'd0, 64'd0);
        expect_out(O_VALA, "pop_valA", 64'hF8);
        expect_out(O_VALE, "pop_valE", 64'h100);
        expect_out(O_VALM, "pop_valM", 64'hDEAD);
        step();
        read_reg(4'h5, "pop_r5", 64'hDEAD);
        read_reg(4'h4, "pop_rsp", 64'h100);

        // popq %rsp: the loaded word wins over the incremented pointer
        irmov(4'h4, 64'hF8);
        drive(4'hB, 4'h0, 4'h4, 4'hF, 64'd0, 64'd0);
        step();
        read_reg(4'h4, "poprsp", 64'hDEAD);

        // call / ret
        irmov(4'h4, 64'h100);
        drive(4'h8, 4'h0, 4'hF, 4'hF, 64'd0, 64'h40);
        expect_out(O_VALE, "call_valE", 64'hF8);
        step();
        read_reg(4'h4, "call_rsp", 64'hF8);
        drive(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_VALM, "ret_valM", 64'h40);
        expect_out(O_VALE, "ret_valE", 64'h100);
        step();
        read_reg(4'h4, "ret_rsp", 64'h100);

        // Error statuses
        drive(4'h4, 4'h0, 4'h2, 4'hF, 64'(DMEM_BYTES - 4), 64'd0);
        expect_out(O_STAT, "adr_stat", 64'd2);
        step();
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'(DMEM_BYTES - 8), 64'd0);
        expect_out(O_VALM, "adr_nowr_hi", 64'd0);
        expect_out(O_STAT, "edge_ok", 64'd0);
        step();
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'd0, 64'd0);
        expect_out(O_VALM, "adr_nowr_lo", 64'd0);
        step();
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
        expect_out(O_STAT, "adr_wrap", 64'd2);
        expect_out(O_VALM, "adr_valM", 64'd0);
        step();
        drive(4'h3, 4'h0, 4'hF, 4'h9, 64'h55, 64'd0, 1'b0, 1'b0);
        expect_out(O_STAT, "ins_stat", 64'd3);
        step();
        read_reg(4'h9, "ins_nowr", 64'd0);
        drive(4'h3, 4'h0, 4'hF, 4'hA, 64'h66, 64'd0, 1'b0, 1'b1);
        expect_out(O_STAT, "imem_prio", 64'd2);
        step();
        read_reg(4'hA, "imem_nowr", 64'd0);
        drive(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_STAT, "hlt_stat", 64'd1);
        step();

        // Signed overflow
        irmov(4'h2, 64'h7FFF_FFFF_FFFF_FFFF);
        irmov(4'h3, 64'd1);
        drive(4'h6, 4'h0, 4'h3, 4'h2, 64'd0, 64'd0);
        expect_out(O_VALE, "ovf_valE", 64'h8000_0000_0000_0000);
        step();
        drive(4'h7, 4'h2, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "jl_ovf", 64'd0);
        step();
        drive(4'h7, 4'h5, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "jge_ovf", 64'd1);
        step();
        drive(4'h6, 4'h1, 4'h3, 4'h2, 64'd0, 64'd0);
        expect_out(O_VALE, "subovf_valE", 64'h7FFF_FFFF_FFFF_FFFF);
        step();
        drive(4'h7, 4'h2, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "jl_subovf", 64'd1);
        step();
        drive(4'h6, 4'h3, 4'h3, 4'h3, 64'd0, 64'd0);
        expect_out(O_VALE, "xor_valE", 64'd0);
        step();
        drive(4'h7, 4'h6, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "jg_zero", 64'd0);
        step();

        // Reset overrides a write in the same cycle
        drive(4'h3, 4'h0, 4'hF, 4'h2, 64'h77, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        read_reg(4'h2, "rst_override", 64'd0);
        drive(4'h5, 4'h0, 4'h8, 4'hF, 64'hF8, 64'd0);
        expect_out(O_VALM, "rst_mem", 64'd0);
        step();
        drive(4'h7, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        expect_out(O_CND, "rst_jle", 64'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
